// File: rtl/pci_conf_init_master.sv
// Wishbone classic master that writes a fixed seven-entry configuration list into
// the PCI bridge and optionally reads it back, reporting the first failure it hits.
module pci_conf_init_master #(
    parameter logic [31:0] CONF_BASE        = 32'h0000_0000,
    parameter logic [31:0] TAR0_BASE_ADDR_0 = 32'h1000_0000,
    parameter logic [31:0] W_BASE_ADDR_1    = 32'hC000_0000,
    parameter int          TIMEOUT_CYCLES   = 256,
    parameter int          RETRY_MAX        = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        verify_en_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [2:0]  fail_idx_o,
    output logic [1:0]  fail_code_o,
    output logic [31:0] fail_data_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RTY_LAST  = RW'(RETRY_MAX);
    localparam logic [2:0]    LAST_IDX  = 3'd6;
    localparam logic [1:0]    CODE_ERR  = 2'd1;
    localparam logic [1:0]    CODE_TMO  = 2'd2;
    localparam logic [1:0]    CODE_CMP  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, WRITE, W_GAP, READ, R_GAP, CHECK, DONE, FAIL
    } state_t;

    function automatic logic [11:0] ent_off(input logic [2:0] i);
        case (i)
            3'd0:    return 12'h004;
            3'd1:    return 12'h010;
            3'd2:    return 12'h108;
            3'd3:    return 12'h188;
            3'd4:    return 12'h18C;
            3'd5:    return 12'h190;
            default: return 12'h1EC;
        endcase
    endfunction

    function automatic logic [31:0] ent_data(input logic [2:0] i);
        case (i)
            3'd0:    return 32'h0000_0007;
            3'd1:    return TAR0_BASE_ADDR_0;
            3'd2:    return 32'hFFFF_0000;
            3'd3:    return W_BASE_ADDR_1;
            3'd4:    return 32'hFFFF_0000;
            3'd5:    return W_BASE_ADDR_1;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] ent_mask(input logic [2:0] i);
        case (i)
            3'd0:    return 32'h0000_0007;
            3'd6:    return 32'h0000_0000;
            default: return 32'hFFFF_0000;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          verify_q, verify_d;
    logic          reissue_q, reissue_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [2:0]    fail_idx_q, fail_idx_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [31:0]   fail_data_q, fail_data_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            verify_q    <= 1'b0;
            reissue_q   <= 1'b0;
            retry_q     <= '0;
            tmo_q       <= '0;
            rdata_q     <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_code_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            verify_q    <= verify_d;
            reissue_q   <= reissue_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_idx_q  <= fail_idx_d;
            fail_code_q <= fail_code_d;
            fail_data_q <= fail_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        verify_d    = verify_q;
        reissue_d   = reissue_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_idx_d  = fail_idx_q;
        fail_code_d = fail_code_q;
        fail_data_d = fail_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_idx_d  = '0;
                    fail_code_d = '0;
                    fail_data_d = '0;
                    verify_d    = verify_en_i;
                    idx_d       = '0;
                    retry_d     = '0;
                    tmo_d       = '0;
                    reissue_d   = 1'b0;
                    state_d     = WRITE;
                end
            end
            WRITE, READ: begin
                // Termination priority: err, then rty, then ack.
                if (wbm_err_i) begin
                    fail_idx_d  = idx_q;
                    fail_code_d = CODE_ERR;
                    state_d     = FAIL;
                end else if (wbm_rty_i) begin
                    if (retry_q == RTY_LAST) begin
                        fail_idx_d  = idx_q;
                        fail_code_d = CODE_TMO;
                        state_d     = FAIL;
                    end else begin
                        retry_d   = retry_q + 1'b1;
                        reissue_d = 1'b1;
                        state_d   = (state_q == WRITE) ? W_GAP : R_GAP;
                    end
                end else if (wbm_ack_i) begin
                    if (state_q == WRITE) begin
                        state_d = W_GAP;
                    end else begin
                        rdata_d = wbm_dat_i;
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fail_idx_d  = idx_q;
                    fail_code_d = CODE_TMO;
                    state_d     = FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            W_GAP: begin
                tmo_d = '0;
                if (reissue_q) begin
                    reissue_d = 1'b0;
                    state_d   = WRITE;
                end else if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 3'd1;
                    retry_d = '0;
                    state_d = WRITE;
                end else if (verify_q) begin
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            CHECK: begin
                if (((rdata_q ^ ent_data(idx_q)) & ent_mask(idx_q)) != 32'd0) begin
                    fail_idx_d  = idx_q;
                    fail_code_d = CODE_CMP;
                    fail_data_d = rdata_q;
                    state_d     = FAIL;
                end else begin
                    state_d = R_GAP;
                end
            end
            R_GAP: begin
                tmo_d = '0;
                if (reissue_q) begin
                    reissue_d = 1'b0;
                    state_d   = READ;
                end else if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 3'd1;
                    retry_d = '0;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they leave the flops clean.
        cyc_d  = (state_d == WRITE) || (state_d == READ);
        we_d   = (state_d == WRITE);
        adr_d  = cyc_d ? (CONF_BASE + {20'd0, ent_off(idx_d)}) : 32'd0;
        dat_d  = we_d ? ent_data(idx_d) : 32'd0;
        busy_d = (state_d != IDLE);
    end

    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = {4{cyc_q}};
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_idx_o  = fail_idx_q;
    assign fail_code_o = fail_code_q;
    assign fail_data_o = fail_data_q;
endmodule

// File: tb/tb_pci_conf_init_master.sv
// Directed bench: a RAM-like Wishbone slave with injectable err/rty/silence/readback
// overrides, a table of whole-sequence scenarios, and hand-written timing sequences.
module tb_pci_conf_init_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        verify_en = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, fail_data_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic        ack_i, err_i, rty_i;
    logic        busy_o, done_o, fail_o;
    logic [2:0]  fail_idx_o;
    logic [1:0]  fail_code_o;

    always #5 clk = ~clk;

    pci_conf_init_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .verify_en_i(verify_en),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_idx_o(fail_idx_o),
        .fail_code_o(fail_code_o), .fail_data_o(fail_data_o)
    );

    // slave controls, written only by the stimulus process
    logic        err_en = 1'b0, sil_en = 1'b0, ovr_en = 1'b0;
    logic [11:0] err_off = '0, sil_off = '0, ovr_off = '0, rty_off = '0;
    logic [31:0] ovr_val = '0;
    int          rty_limit = 0;

    // slave state, written only by the monitor
    logic [31:0] mem [0:1023];
    logic [31:0] log_adr [0:1023];
    logic [31:0] log_dat [0:1023];
    logic        log_we  [0:1023];
    int          n_acc = 0;
    int          rty_total = 0;

    // err and rty are raised together with ack to exercise termination priority
    always_comb begin
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; wbm_dat_i = 32'd0;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (err_en && wbm_adr_o[11:0] == err_off) begin
                err_i = 1'b1; ack_i = 1'b1;
            end else if (wbm_adr_o[11:0] == rty_off && rty_total < rty_limit) begin
                rty_i = 1'b1; ack_i = 1'b1;
            end else if (!(sil_en && wbm_adr_o[11:0] == sil_off)) begin
                ack_i = 1'b1;
            end
            wbm_dat_i = (ovr_en && !wbm_we_o && wbm_adr_o[11:0] == ovr_off) ? ovr_val
                                                                             : mem[wbm_adr_o[11:2]];
        end
    end

    always @(posedge clk) begin
        if (wbm_cyc_o && rty_i) rty_total <= rty_total + 1;
        if (wbm_cyc_o && ack_i && !err_i && !rty_i) begin
            log_adr[n_acc % 1024] <= wbm_adr_o;
            log_we[n_acc % 1024]  <= wbm_we_o;
            log_dat[n_acc % 1024] <= wbm_we_o ? wbm_dat_o : wbm_dat_i;
            if (wbm_we_o) mem[wbm_adr_o[11:2]] <= wbm_dat_o;
            n_acc <= n_acc + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic v);
        @(negedge clk);
        verify_en = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (busy_o && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic clear_slave();
        err_en = 1'b0; sil_en = 1'b0; ovr_en = 1'b0;
        rty_limit = rty_total;
    endtask

    typedef struct {
        string       name;
        logic        verify;
        logic        ovr_en;
        logic [11:0] ovr_off;
        logic [31:0] ovr_val;
        int          rty_n;
        logic [11:0] rty_off;
        logic        err_en;
        logic [11:0] err_off;
        logic        sil_en;
        logic [11:0] sil_off;
        logic        e_done;
        logic        e_fail;
        logic [2:0]  e_idx;
        logic [1:0]  e_code;
        logic [31:0] e_data;
        int          e_acc;
    } vec_t;

    function automatic vec_t mk(string n, logic v, logic oe, logic [11:0] oo, logic [31:0] ov,
                                int rn, logic [11:0] ro, logic ee, logic [11:0] eo,
                                logic se, logic [11:0] so, logic ed, logic ef,
                                logic [2:0] ei, logic [1:0] ec, logic [31:0] edat, int ea);
        vec_t r;
        r.name = n; r.verify = v; r.ovr_en = oe; r.ovr_off = oo; r.ovr_val = ov;
        r.rty_n = rn; r.rty_off = ro; r.err_en = ee; r.err_off = eo;
        r.sil_en = se; r.sil_off = so; r.e_done = ed; r.e_fail = ef;
        r.e_idx = ei; r.e_code = ec; r.e_data = edat; r.e_acc = ea;
        return r;
    endfunction

    logic [11:0] exp_off [0:6];
    logic [31:0] exp_dat [0:6];
    vec_t        vecs [0:10];

    initial begin
        int base, hi, seen, first_done;
        exp_off = '{12'h004, 12'h010, 12'h108, 12'h188, 12'h18C, 12'h190, 12'h1EC};
        exp_dat = '{32'h0000_0007, 32'h1000_0000, 32'hFFFF_0000, 32'hC000_0000,
                    32'hFFFF_0000, 32'hC000_0000, 32'h0000_0000};
        //               name        vfy ovr off      val            rty off      err off      sil off    done fail idx code data acc
        vecs[0]  = mk("wr_only",    0, 0, 12'h0,   32'h0,         0, 12'h0,   0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 7);
        vecs[1]  = mk("wr_verify",  1, 0, 12'h0,   32'h0,         0, 12'h0,   0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 14);
        vecs[2]  = mk("bar0_mask",  1, 1, 12'h010, 32'h1000_0ABC, 0, 12'h0,   0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 14);
        vecs[3]  = mk("bar0_bad",   1, 1, 12'h010, 32'h2000_0000, 0, 12'h0,   0, 12'h0,   0, 12'h0,   0, 1, 1, 3, 32'h2000_0000, 9);
        vecs[4]  = mk("pam0_bad",   1, 1, 12'h108, 32'h7FFF_0000, 0, 12'h0,   0, 12'h0,   0, 12'h0,   0, 1, 2, 3, 32'h7FFF_0000, 10);
        vecs[5]  = mk("icr_nochk",  1, 1, 12'h1EC, 32'hFFFF_FFFF, 0, 12'h0,   0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 14);
        vecs[6]  = mk("rty3",       0, 0, 12'h0,   32'h0,         3, 12'h188, 0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 7);
        vecs[7]  = mk("rty4",       0, 0, 12'h0,   32'h0,         4, 12'h188, 0, 12'h0,   0, 12'h0,   0, 1, 3, 2, 32'h0, 3);
        vecs[8]  = mk("err0",       0, 0, 12'h0,   32'h0,         0, 12'h0,   1, 12'h004, 0, 12'h0,   0, 1, 0, 1, 32'h0, 0);
        vecs[9]  = mk("silent",     0, 0, 12'h0,   32'h0,         0, 12'h0,   0, 12'h0,   1, 12'h108, 0, 1, 2, 2, 32'h0, 2);
        vecs[10] = mk("rty2_vfy",   1, 0, 12'h0,   32'h0,         2, 12'h010, 0, 12'h0,   0, 12'h0,   1, 0, 0, 0, 32'h0, 14);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        chk("rst_flags", {26'd0, busy_o, done_o, fail_o, fail_idx_o}, 32'd0);
        chk("rst_code", {30'd0, fail_code_o}, 32'd0);
        chk("rst_fdata", fail_data_o, 32'd0);
        rst = 1'b0;
        clear_slave();

        // write-only timing: done_o first seen on the 16th edge counting the start edge as 1
        pulse_start(1'b0);
        chk("t1_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        chk("t1_sel", {28'd0, wbm_sel_o}, 32'hF);
        first_done = 0;
        for (int n = 1; n < 40 && first_done == 0; n++) begin
            if (done_o) first_done = n;
            else @(negedge clk);
        end
        chk("done_cycle", first_done, 16);
        chk("done_busy", {31'd0, busy_o}, 32'd0);

        // scenario table
        for (int i = 0; i < 11; i++) begin
            clear_slave();
            ovr_en = vecs[i].ovr_en; ovr_off = vecs[i].ovr_off; ovr_val = vecs[i].ovr_val;
            rty_off = vecs[i].rty_off; rty_limit = rty_total + vecs[i].rty_n;
            err_en = vecs[i].err_en; err_off = vecs[i].err_off;
            sil_en = vecs[i].sil_en; sil_off = vecs[i].sil_off;
            base = n_acc;
            pulse_start(vecs[i].verify);
            wait_idle({vecs[i].name, "_idle"}, 3000);
            @(negedge clk);
            chk({vecs[i].name, "_done"}, {31'd0, done_o}, {31'd0, vecs[i].e_done});
            chk({vecs[i].name, "_fail"}, {31'd0, fail_o}, {31'd0, vecs[i].e_fail});
            chk({vecs[i].name, "_idx"}, {29'd0, fail_idx_o}, {29'd0, vecs[i].e_idx});
            chk({vecs[i].name, "_code"}, {30'd0, fail_code_o}, {30'd0, vecs[i].e_code});
            chk({vecs[i].name, "_fdata"}, fail_data_o, vecs[i].e_data);
            chk({vecs[i].name, "_nacc"}, n_acc - base, vecs[i].e_acc);
        end

        // access order and contents with verify: all writes before any read
        clear_slave();
        base = n_acc;
        pulse_start(1'b1);
        wait_idle("log_idle", 3000);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("log%0d_adr", i), log_adr[(base + i) % 1024], {20'd0, exp_off[i % 7]});
            chk($sformatf("log%0d_we", i), {31'd0, log_we[(base + i) % 1024]}, (i < 7) ? 32'd1 : 32'd0);
            chk($sformatf("log%0d_dat", i), log_dat[(base + i) % 1024], exp_dat[i % 7]);
        end

        // four rty on W_BA1: bus must go quiet right after the last one
        clear_slave();
        rty_off = 12'h188; rty_limit = rty_total + 4;
        pulse_start(1'b0);
        seen = 0;
        for (int c = 0; c < 200 && seen < 4; c++) begin
            if (wbm_cyc_o && rty_i) seen++;
            if (seen < 4) @(negedge clk);
        end
        chk("rty4_seen", seen, 4);
        @(negedge clk);
        chk("rty4_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rty4_still_low", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rty4_fail", {31'd0, fail_o}, 32'd1);

        // silent slave on P_AM0: cyc stays high for exactly the timeout window
        clear_slave();
        sil_en = 1'b1; sil_off = 12'h108;
        pulse_start(1'b0);
        for (int c = 0; c < 50 && !(wbm_cyc_o && wbm_adr_o[11:0] == 12'h108); c++) @(negedge clk);
        hi = 0;
        while (wbm_cyc_o && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        chk("tmo_len", hi, 256);
        wait_idle("tmo_idle", 50);
        @(negedge clk);
        chk("tmo_code", {30'd0, fail_code_o}, 32'd2);
        chk("tmo_idx", {29'd0, fail_idx_o}, 32'd2);

        // start while busy is ignored, including its verify_en
        clear_slave();
        base = n_acc;
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        pulse_start(1'b1);
        wait_idle("rst_busy_idle", 3000);
        @(negedge clk);
        chk("busy_start_nacc", n_acc - base, 7);
        chk("busy_start_done", {31'd0, done_o}, 32'd1);

        // reset during an access
        clear_slave();
        sil_en = 1'b1; sil_off = 12'h108;
        pulse_start(1'b0);
        for (int c = 0; c < 50 && !(wbm_cyc_o && wbm_adr_o[11:0] == 12'h108); c++) @(negedge clk);
        chk("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        chk("mid_rst_adr", wbm_adr_o, 32'd0);
        chk("mid_rst_flags", {29'd0, busy_o, done_o, fail_o}, 32'd0);
        rst = 1'b0;
        clear_slave();
        repeat (2) @(negedge clk);
        chk("post_rst_quiet", {30'd0, wbm_cyc_o, fail_o}, 32'd0);

        // fresh start after reset runs from index 0
        base = n_acc;
        pulse_start(1'b0);
        chk("fresh_adr0", wbm_adr_o, 32'h0000_0004);
        chk("fresh_dat0", wbm_dat_o, 32'h0000_0007);
        wait_idle("fresh_idle", 3000);
        @(negedge clk);
        chk("fresh_nacc", n_acc - base, 7);
        chk("fresh_done", {30'd0, done_o, fail_o}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
